// File: rtl/issue_scheduler.sv
// issue_scheduler
//   Oldest-first select and wakeup controller for an ENTRIES-slot issue queue.
//   Dispatch allocates slots with two source tags. Result broadcasts wake
//   those tags. Each cycle the oldest fully-ready slot is offered to the single
//   execution port. A slot whose functional-unit occupancy is greater than one
//   cycle (the divider) is held back while the divider is still busy.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   flush_i           kill every entry, the offer lock and the busy counter
//   alloc_valid_i     allocate slot alloc_idx_i this cycle
//   alloc_idx_i       slot being allocated (must currently be free)
//   alloc_src_tag_i   {src1_tag, src0_tag}
//   alloc_src_rdy_i   {src1_rdy, src0_rdy} at dispatch
//   alloc_occ_i       FU occupancy in cycles (0/1 = pipelined)
//   wake_valid_i      per-port broadcast valid
//   wake_tag_i        per-port broadcast tag, port 0 in the low bits
//   free_mask_o       1 = slot free
//   issue_valid_o     a slot is offered to execute
//   issue_idx_o       offered slot
//   issue_ready_i     execute accepts the offered slot
//   fu_busy_o         the non-pipelined FU is occupied
module issue_scheduler #(
  parameter int ENTRIES    = 8,
  parameter int TAG_W      = 6,
  parameter int WAKE_PORTS = 2,
  parameter int LAT_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        alloc_valid_i,
  input  logic [$clog2(ENTRIES)-1:0]  alloc_idx_i,
  input  logic [2*TAG_W-1:0]          alloc_src_tag_i,
  input  logic [1:0]                  alloc_src_rdy_i,
  input  logic [LAT_W-1:0]            alloc_occ_i,
  input  logic [WAKE_PORTS-1:0]       wake_valid_i,
  input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag_i,
  output logic [ENTRIES-1:0]          free_mask_o,
  output logic                        issue_valid_o,
  output logic [$clog2(ENTRIES)-1:0]  issue_idx_o,
  input  logic                        issue_ready_i,
  output logic                        fu_busy_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Control state (reset)
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] older [ENTRIES];   // older[i][j]: slot i older than slot j
  logic               lock_vld;
  logic [IDX_W-1:0]   lock_idx;
  logic [LAT_W-1:0]   busy_cnt;

  // Payload state (only meaningful while the slot is valid)
  logic [1:0]         rdy [ENTRIES];
  logic [TAG_W-1:0]   tag [ENTRIES][2];
  logic [LAT_W-1:0]   occ [ENTRIES];

  logic [ENTRIES-1:0] cand;
  logic [ENTRIES-1:0] grant;
  logic [IDX_W-1:0]   sel_idx;
  logic [ENTRIES-1:0] valid_nxt;
  logic               accept;
  logic               alloc_ok;
  logic [1:0]         alloc_hit;

  function automatic logic wake_hit(input logic [TAG_W-1:0]            t,
                                    input logic [WAKE_PORTS-1:0]       wv,
                                    input logic [WAKE_PORTS*TAG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wv[p] && (wt[p*TAG_W +: TAG_W] == t)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Select: decoded from registered state only
  assign fu_busy_o = (busy_cnt != '0);

  always_comb begin
    cand = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      cand[i] = valid[i] & rdy[i][0] & rdy[i][1]
              & ~((occ[i] > LAT_W'(1)) & fu_busy_o);
    end
  end

  // A candidate wins when no other candidate is older than it; the age
  // matrix is a total order over valid slots, so the grant is one-hot.
  always_comb begin
    grant   = '0;
    sel_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < ENTRIES; j++) begin
        if ((j != i) && cand[j] && older[j][i]) blocked = 1'b1;
      end
      grant[i] = cand[i] & ~blocked;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant[i]) sel_idx = sel_idx | IDX_W'(i);
    end
  end

  // A held offer keeps its slot even if an older slot becomes ready.
  assign issue_valid_o = lock_vld | (|cand);
  assign issue_idx_o   = lock_vld ? lock_idx : sel_idx;
  assign free_mask_o   = ~valid;

  assign accept   = issue_valid_o & issue_ready_i;
  assign alloc_ok = alloc_valid_i & ~valid[alloc_idx_i] & ~flush_i;

  always_comb begin
    alloc_hit[0] = wake_hit(alloc_src_tag_i[0 +: TAG_W], wake_valid_i, wake_tag_i);
    alloc_hit[1] = wake_hit(alloc_src_tag_i[TAG_W +: TAG_W], wake_valid_i, wake_tag_i);
  end

  always_comb begin
    valid_nxt = valid;
    if (accept)   valid_nxt[issue_idx_o] = 1'b0;
    if (alloc_ok) valid_nxt[alloc_idx_i] = 1'b1;
    if (flush_i)  valid_nxt = '0;
  end

  // Control registers: validity, age, offer lock, divider busy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      busy_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) older[i] <= '0;
    end else begin
      valid <= valid_nxt;

      if (flush_i || accept) begin
        lock_vld <= 1'b0;
      end else if (issue_valid_o) begin
        lock_vld <= 1'b1;
        lock_idx <= issue_idx_o;
      end

      // Flush wins over an accept in the same cycle: no counter load.
      if (flush_i) begin
        busy_cnt <= '0;
      end else if (accept && (occ[issue_idx_o] > LAT_W'(1))) begin
        busy_cnt <= occ[issue_idx_o] - LAT_W'(1);
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - LAT_W'(1);
      end

      // New entry becomes the youngest: every valid slot is older than it,
      // and it is older than nothing.
      if (alloc_ok) begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (valid[j]) older[j][alloc_idx_i] <= 1'b1;
        end
        older[alloc_idx_i] <= '0;
      end
    end
  end

  // Payload registers: tags, occupancy, readiness with same-cycle bypass
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (alloc_ok && (alloc_idx_i == IDX_W'(i))) begin
        tag[i][0] <= alloc_src_tag_i[0 +: TAG_W];
        tag[i][1] <= alloc_src_tag_i[TAG_W +: TAG_W];
        occ[i]    <= alloc_occ_i;
        rdy[i]    <= alloc_src_rdy_i | alloc_hit;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (valid[i] && wake_hit(tag[i][s], wake_valid_i, wake_tag_i))
            rdy[i][s] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler
//   Directed, table-driven bench for issue_scheduler with default parameters
//   (8 slots, 6-bit tags, 2 wake ports, 4-bit occupancy). Each record is one
//   clock cycle: inputs are driven just after the rising edge and the
//   outputs of that same cycle, which depend only on registered state, are
//   compared at the falling edge.
module tb_issue_scheduler;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        alloc_valid_i;
  logic [2:0]  alloc_idx_i;
  logic [11:0] alloc_src_tag_i;
  logic [1:0]  alloc_src_rdy_i;
  logic [3:0]  alloc_occ_i;
  logic [1:0]  wake_valid_i;
  logic [11:0] wake_tag_i;
  logic [7:0]  free_mask_o;
  logic        issue_valid_o;
  logic [2:0]  issue_idx_o;
  logic        issue_ready_i;
  logic        fu_busy_o;

  issue_scheduler #(
    .ENTRIES(8), .TAG_W(6), .WAKE_PORTS(2), .LAT_W(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_idx_i    (alloc_idx_i),
    .alloc_src_tag_i(alloc_src_tag_i),
    .alloc_src_rdy_i(alloc_src_rdy_i),
    .alloc_occ_i    (alloc_occ_i),
    .wake_valid_i   (wake_valid_i),
    .wake_tag_i     (wake_tag_i),
    .free_mask_o    (free_mask_o),
    .issue_valid_o  (issue_valid_o),
    .issue_idx_o    (issue_idx_o),
    .issue_ready_i  (issue_ready_i),
    .fu_busy_o      (fu_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       av;
    logic [2:0] ai;
    logic [5:0] t0;
    logic [5:0] t1;
    logic [1:0] ar;
    logic [3:0] ao;
    logic [1:0] wv;
    logic [5:0] w0;
    logic [5:0] w1;
    logic       ir;
    logic       chk;
    logic [7:0] e_free;
    logic       e_iv;
    logic [2:0] e_idx;
    logic       e_busy;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic prev_rst = 1'b0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic fl, input logic av,
                              input logic [2:0] ai, input logic [5:0] t0,
                              input logic [5:0] t1, input logic [1:0] ar,
                              input logic [3:0] ao, input logic [1:0] wv,
                              input logic [5:0] w0, input logic [5:0] w1,
                              input logic ir, input logic chk,
                              input logic [7:0] ef, input logic eiv,
                              input logic [2:0] eidx, input logic eb);
    vec_t v;
    v.rst = r;  v.fl = fl; v.av = av; v.ai = ai; v.t0 = t0; v.t1 = t1;
    v.ar = ar;  v.ao = ao; v.wv = wv; v.w0 = w0; v.w1 = w1; v.ir = ir;
    v.chk = chk; v.e_free = ef; v.e_iv = eiv; v.e_idx = eidx; v.e_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(posedge clk);
    #1;
    // Dispatch may only allocate a slot the scheduler reports as free.
    if (v.av && !v.rst) check({name, " alloc_slot_free"}, {7'd0, free_mask_o[v.ai]}, 8'd1);
    rst             = v.rst;
    flush_i         = v.fl;
    alloc_valid_i   = v.av;
    alloc_idx_i     = v.ai;
    alloc_src_tag_i = {v.t1, v.t0};
    alloc_src_rdy_i = v.ar;
    alloc_occ_i     = v.ao;
    wake_valid_i    = v.wv;
    wake_tag_i      = {v.w1, v.w0};
    issue_ready_i   = v.ir;
    @(negedge clk);
    if (v.chk) begin
      check({name, " free_mask"}, free_mask_o, v.e_free);
      check({name, " issue_valid"}, {7'd0, issue_valid_o}, {7'd0, v.e_iv});
      check({name, " fu_busy"}, {7'd0, fu_busy_o}, {7'd0, v.e_busy});
      if (v.e_iv || prev_rst)
        check({name, " issue_idx"}, {5'd0, issue_idx_o}, {5'd0, v.e_idx});
    end
    prev_rst = v.rst;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_idx_i = '0;
    alloc_src_tag_i = '0; alloc_src_rdy_i = '0; alloc_occ_i = '0;
    wake_valid_i = '0; wake_tag_i = '0; issue_ready_i = 1'b0;

    //            rst fl av ai  t0 t1 ar ao  wv w0 w1 ir  chk free   iv idx busy
    // reset, in-order issue of 3, 1, 5
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  0, 8'hFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3,  0, 0, 3, 0,  0, 0, 0, 1,  1, 8'hFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1,  0, 0, 3, 0,  0, 0, 0, 1,  1, 8'hF7, 1, 3, 0));
    tbl.push_back(mk(0, 0, 1, 5,  0, 0, 3, 0,  0, 0, 0, 1,  1, 8'hFD, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hDF, 1, 5, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hFF, 0, 0, 0));
    // wakeup ordering: slot 0 waits on tag 12, younger ready slot 1 goes first
    tbl.push_back(mk(0, 0, 1, 0, 12, 0, 2, 0,  0, 0, 0, 1,  1, 8'hFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1,  0, 0, 3, 0,  0, 0, 0, 1,  1, 8'hFE, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  1,12, 0, 1,  1, 8'hFC, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hFE, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hFF, 0, 0, 0));
    // lock under backpressure: slot 2 held while older slot 6 wakes
    tbl.push_back(mk(0, 0, 1, 6, 20, 0, 2, 0,  0, 0, 0, 0,  1, 8'hFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2,  0, 0, 3, 0,  0, 0, 0, 0,  1, 8'hBF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  1,20, 0, 0,  1, 8'hBB, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 8'hBB, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 8'hBB, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hBB, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hBF, 1, 6, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hFF, 0, 0, 0));
    // divider gating: slot 0 occ=5 accepted, slot 2 (occ=1) passes slot 1 (occ=5)
    tbl.push_back(mk(0, 0, 1, 0,  0, 0, 3, 5,  0, 0, 0, 0,  1, 8'hFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1,  0, 0, 3, 5,  0, 0, 0, 0,  1, 8'hFE, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2,  0, 0, 3, 1,  0, 0, 0, 1,  1, 8'hFC, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hF9, 1, 2, 1));
    tbl.push_back(mk(0, 0, 1, 4, 30,31, 0, 0,  0, 0, 0, 1,  1, 8'hFD, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 5, 32,33, 0, 0,  0, 0, 0, 1,  1, 8'hED, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 6, 34,35, 0, 0,  0, 0, 0, 1,  1, 8'hCD, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 7, 36,37, 0, 0,  0, 0, 0, 1,  1, 8'h8D, 1, 1, 0));
    // flush mid-busy with a same-cycle allocation that must be dropped
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'h0F, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0,  0, 0, 3, 1,  0, 0, 0, 1,  1, 8'h0F, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hFF, 0, 0, 0));
    // same-cycle allocation and wake on port 1
    tbl.push_back(mk(0, 0, 1, 4,  9, 0, 2, 0,  2, 0, 9, 1,  1, 8'hFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hEF, 1, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hFF, 0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("v%0d", k));

    // occ=2 boundary: busy for exactly one cycle, then reset overrides a
    // pending offer and a nonzero busy counter.
    apply(mk(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  0, 8'hFF, 0, 0, 0), "h0");
    apply(mk(0, 0, 1, 3,  0, 0, 3, 2,  0, 0, 0, 1,  1, 8'hFF, 0, 0, 0), "h1");
    apply(mk(0, 0, 1, 5,  0, 0, 3, 3,  0, 0, 0, 1,  1, 8'hF7, 1, 3, 0), "h2");
    apply(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hDF, 0, 0, 1), "h3");
    apply(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  1, 8'hDF, 1, 5, 0), "h4");
    apply(mk(0, 0, 1, 2,  0, 0, 3, 0,  0, 0, 0, 0,  1, 8'hFF, 0, 0, 1), "h5");
    apply(mk(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 8'hFB, 1, 2, 1), "h6");
    apply(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 8'hFF, 0, 0, 0), "h7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
